// File: rtl/vga_cell_buffer.sv
// Cell-grid pixel source for the VGA display stage: 2-clock read pipeline, handshake cell writes, hardware clear.
// Optional VGA_CURSOR_EN: inverts the border pixels of the last written cell.
module vga_cell_buffer #(
    parameter int unsigned CELL_SHIFT = 3,
    parameter int unsigned GRID_BITS  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           iCol,
    input  logic [7:0]           iRow,
    output logic                 oR,
    output logic                 oG,
    output logic                 oB,
    input  logic                 iWrValid,
    output logic                 oWrReady,
    input  logic [GRID_BITS-1:0] iWrX,
    input  logic [GRID_BITS-1:0] iWrY,
    input  logic [2:0]           iWrColor,
    input  logic                 iClear,
    input  logic [2:0]           iClearColor,
    output logic                 oBusy
);

    localparam int unsigned ADDR_W = 2 * GRID_BITS;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (CELL_SHIFT + GRID_BITS != 8) begin : g_bad_geometry
        $error("vga_cell_buffer: CELL_SHIFT + GRID_BITS must equal 8");
    end

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [2:0]          fill_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic [2:0]          rgb_q;
    logic [2:0]          pix_mask_c;
    logic                wr_fire_c;
    logic                ram_we_c;
    logic [ADDR_W-1:0]   ram_waddr_c;
    logic [2:0]          ram_wdata_c;

    logic [2:0] mem [DEPTH];

    // A clear request in IDLE blocks the same-cycle write
    assign oWrReady  = (state_q == ST_IDLE) & ~iClear;
    assign oBusy     = (state_q == ST_CLEAR);
    assign wr_fire_c = iWrValid & oWrReady;
    assign rd_addr_d = ADDR_W'({iRow[7:CELL_SHIFT], iCol[7:CELL_SHIFT]});

    // RAM write port: clear sweep has priority, nothing is written while in reset
    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = '0;
        ram_wdata_c = '0;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                ram_we_c    = 1'b1;
                ram_waddr_c = clr_cnt_q;
                ram_wdata_c = fill_q;
            end else if (wr_fire_c) begin
                ram_we_c    = 1'b1;
                ram_waddr_c = ADDR_W'({iWrY, iWrX});
                ram_wdata_c = iWrColor;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we_c) begin
            mem[ram_waddr_c] <= ram_wdata_c;
        end
    end

    // Clear FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            fill_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iClear) begin
                        fill_q    <= iClearColor;
                        clr_cnt_q <= '0;
                        state_q   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef VGA_CURSOR_EN
    logic [ADDR_W-1:0]     cursor_q;
    logic [CELL_SHIFT-1:0] col_lo_q;
    logic [CELL_SHIFT-1:0] row_lo_q;
    logic                  border_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            cursor_q <= '0;
            col_lo_q <= '0;
            row_lo_q <= '0;
        end else begin
            col_lo_q <= iCol[CELL_SHIFT-1:0];
            row_lo_q <= iRow[CELL_SHIFT-1:0];
            if (wr_fire_c) begin
                cursor_q <= ADDR_W'({iWrY, iWrX});
            end
        end
    end

    // Border position comes from the address stage so the outline adds no latency
    assign border_c   = (col_lo_q == '0) | (col_lo_q == '1) | (row_lo_q == '0) | (row_lo_q == '1);
    assign pix_mask_c = {3{border_c & (rd_addr_q == cursor_q)}};
`else
    assign pix_mask_c = 3'b000;
`endif

    // Read pipeline: address register, then data register (old data on write collision)
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr_q <= '0;
            rgb_q     <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rgb_q     <= mem[rd_addr_q] ^ pix_mask_c;
        end
    end

    assign oR = rgb_q[2];
    assign oG = rgb_q[1];
    assign oB = rgb_q[0];

endmodule
